// File: rtl/cim_weight_fetch.sv
// Sequential read engine for the CIM SRAM port B: issues word reads from a base
// address and streams the returned words out through a credit-limited FIFO.
module cim_weight_fetch #(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 18,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  word_count,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] sram_addr_b,
    output logic                  sram_en_b,
    input  logic [DATA_WIDTH-1:0] sram_rdata_b,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic                  w_valid,
    input  logic                  w_ready,
    output logic                  w_last
);

    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [CNT_WIDTH-1:0]  issue_cnt;
    logic [CNT_WIDTH-1:0]  deliv_cnt;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] mem_last;
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [PW:0]           fifo_count;
    logic [PW+1:0]         occupancy;
    logic                  credit, push, pop;
    logic                  load, issue, cmd_zero, finish;

    // Reads already committed: queued words, the word arriving now, and the
    // read presented to the SRAM this cycle.
    assign occupancy = {1'b0, fifo_count} + (PW+2)'(inflight) + (PW+2)'(sram_en_b);
    assign credit    = occupancy < (PW+2)'(FIFO_DEPTH);
    assign push      = inflight;
    assign pop       = w_valid && w_ready;
    assign w_valid   = fifo_count != '0;
    assign w_data    = w_valid ? mem_data[rd_ptr] : '0;
    assign w_last    = w_valid && mem_last[rd_ptr];
    assign busy      = state != IDLE;

    always_comb begin
        state_next = state;
        load       = 1'b0;
        issue      = 1'b0;
        cmd_zero   = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (word_count != '0) begin
                        load       = 1'b1;
                        state_next = FETCH;
                    end else begin
                        cmd_zero = 1'b1;
                    end
                end
            end
            FETCH: begin
                if (issue_cnt == '0) state_next = DRAIN;
                else if (credit)     issue = 1'b1;
            end
            DRAIN: begin
                if (pop && w_last) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            done        <= 1'b0;
            sram_en_b   <= 1'b0;
            sram_addr_b <= '0;
            next_addr   <= '0;
            issue_cnt   <= '0;
            deliv_cnt   <= '0;
            inflight    <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
        end else begin
            state    <= state_next;
            done     <= cmd_zero || finish;
            inflight <= sram_en_b;

            // The first read goes out straight from IDLE to meet the start latency.
            if (load) begin
                sram_en_b   <= 1'b1;
                sram_addr_b <= base_addr;
                next_addr   <= base_addr + 1'b1;
                issue_cnt   <= word_count - 1'b1;
                deliv_cnt   <= word_count;
            end else if (issue) begin
                sram_en_b   <= 1'b1;
                sram_addr_b <= next_addr;
                next_addr   <= next_addr + 1'b1;
                issue_cnt   <= issue_cnt - 1'b1;
            end else begin
                sram_en_b <= 1'b0;
            end

            if (push) begin
                wr_ptr    <= wr_ptr + 1'b1;
                deliv_cnt <= deliv_cnt - 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;

            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= sram_rdata_b;
            mem_last[wr_ptr] <= deliv_cnt == CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_cim_weight_fetch.sv
// Directed and random bench for cim_weight_fetch with an SRAM model
// (mem[a] = a) and an expected-word queue.
module tb_cim_weight_fetch;

    localparam int AW    = 17;
    localparam int DW    = 32;
    localparam int CW    = 18;
    localparam int DEPTH = 4;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [CW-1:0] word_count;
    logic          busy, done;
    logic [AW-1:0] sram_addr_b;
    logic          sram_en_b;
    logic [DW-1:0] sram_rdata_b = '0;
    logic [DW-1:0] w_data;
    logic          w_valid, w_ready, w_last;

    int            checks = 0;
    int            errors = 0;
    exp_t          sb[$];
    logic [AW-1:0] exp_addr;
    int            occ;
    bit            en_prev;
    int            en_count;
    int            transfers;
    bit            done_seen;

    cim_weight_fetch #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .CNT_WIDTH (CW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .word_count  (word_count),
        .busy        (busy),
        .done        (done),
        .sram_addr_b (sram_addr_b),
        .sram_en_b   (sram_en_b),
        .sram_rdata_b(sram_rdata_b),
        .w_data      (w_data),
        .w_valid     (w_valid),
        .w_ready     (w_ready),
        .w_last      (w_last)
    );

    always #5 clk = ~clk;

    // Garbage when not enabled so a mistimed capture shows up as bad data.
    always @(posedge clk) begin
        if (sram_en_b) sram_rdata_b <= 32'(sram_addr_b);
        else           sram_rdata_b <= 32'hDEAD_BEEF;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs before each clock edge on the values of the current cycle.
    task automatic monitor();
        bit   pop;
        exp_t e;
        if (rst) begin
            occ     = 0;
            en_prev = 1'b0;
        end else begin
            check("valid_vs_model", w_valid, occ != 0);
            pop = w_valid && w_ready;
            if (pop) begin
                transfers++;
                if (sb.size() == 0) begin
                    check("unexpected_word", w_data, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("w_data", w_data, e.data);
                    check("w_last", w_last, e.last);
                end
            end
            if (sram_en_b) begin
                check("sram_addr_b", sram_addr_b, exp_addr);
                exp_addr = exp_addr + 1'b1;
                en_count++;
            end
            occ = occ + int'(en_prev) - int'(pop);
            check("fifo_bound", occ > DEPTH, 0);
            en_prev = sram_en_b;
            if (done) begin
                done_seen = 1'b1;
                check("busy_at_done", busy, 0);
            end
        end
    endtask

    task automatic cycle();
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmd(input logic [AW-1:0] base, input int count);
        logic [AW-1:0] a;
        base_addr  = base;
        word_count = CW'(count);
        start      = 1'b1;
        exp_addr   = base;
        en_count   = 0;
        transfers  = 0;
        done_seen  = 1'b0;
        a = base;
        for (int i = 0; i < count; i++) begin
            sb.push_back('{data: 32'(a), last: (i == count - 1)});
            a = a + 1'b1;
        end
    endtask

    task automatic wait_done(input int bound, input bit rand_ready);
        int n = 0;
        while (!done_seen && n < bound) begin
            if (rand_ready) w_ready = 1'($urandom_range(0, 1));
            cycle();
            n++;
        end
        check("done_timeout", done_seen, 1);
        w_ready = 1'b1;
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        base_addr  = '0;
        word_count = '0;
        w_ready    = 1'b1;
        exp_addr   = '0;
        occ        = 0;
        en_prev    = 1'b0;
        en_count   = 0;
        transfers  = 0;
        done_seen  = 1'b0;

        repeat (3) cycle();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_en", sram_en_b, 0);
        check("rst_addr", sram_addr_b, 0);
        check("rst_valid", w_valid, 0);
        check("rst_data", w_data, 0);
        check("rst_last", w_last, 0);
        rst = 1'b0;
        repeat (2) cycle();

        // Basic 8-word fetch with exact cycle timing
        start_cmd(17'h00010, 8);
        cycle();
        start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            check("t1_en", sram_en_b, (k >= 1 && k <= 8));
            check("t1_valid", w_valid, (k >= 3 && k <= 10));
            check("t1_busy", busy, (k <= 10));
            check("t1_done", done, (k == 11));
            cycle();
        end
        check("t1_sb_empty", sb.size(), 0);
        check("t1_transfers", transfers, 8);

        // Stall cycles 3-12: issue stops at 4 outstanding, head stays put
        start_cmd(17'h00010, 8);
        cycle();
        start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            w_ready = !(k >= 3);
            if (k >= 3) begin
                check("t2_hold_valid", w_valid, 1);
                check("t2_hold_data", w_data, 32'h10);
            end
            cycle();
        end
        check("t2_issued_in_stall", en_count, 4);
        w_ready = 1'b1;
        wait_done(100, 1'b0);
        check("t2_sb_empty", sb.size(), 0);
        check("t2_transfers", transfers, 8);
        repeat (2) cycle();

        // Address wrap
        start_cmd(17'h1FFFE, 4);
        cycle();
        start = 1'b0;
        wait_done(50, 1'b0);
        check("t3_sb_empty", sb.size(), 0);
        check("t3_en_count", en_count, 4);
        repeat (2) cycle();

        // Zero-length command
        start_cmd(17'h00123, 0);
        cycle();
        start = 1'b0;
        check("t4_zero_done", done, 1);
        check("t4_zero_busy", busy, 0);
        cycle();
        check("t4_zero_done_pulse", done, 0);
        check("t4_zero_busy2", busy, 0);
        repeat (3) cycle();
        check("t4_zero_no_reads", en_count, 0);

        // Start while busy is ignored
        start_cmd(17'h00200, 16);
        cycle();
        start = 1'b0;
        repeat (4) cycle();
        base_addr  = 17'h05000;
        word_count = 18'd3;
        start      = 1'b1;
        cycle();
        start = 1'b0;
        wait_done(100, 1'b0);
        repeat (4) cycle();
        check("t4_transfers", transfers, 16);
        check("t4_en_count", en_count, 16);
        check("t4_sb_empty", sb.size(), 0);
        check("t4_idle_valid", w_valid, 0);

        // Reset mid-command
        w_ready = 1'b0;
        start_cmd(17'h00300, 16);
        cycle();
        start = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        check("t5_busy", busy, 0);
        check("t5_done", done, 0);
        check("t5_en", sram_en_b, 0);
        check("t5_addr", sram_addr_b, 0);
        check("t5_valid", w_valid, 0);
        check("t5_data", w_data, 0);
        check("t5_last", w_last, 0);
        sb.delete();
        rst       = 1'b0;
        done_seen = 1'b0;
        repeat (6) cycle();
        check("t5_no_done", done_seen, 0);
        check("t5_still_empty", w_valid, 0);
        w_ready = 1'b1;
        start_cmd(17'h00400, 5);
        cycle();
        start = 1'b0;
        wait_done(50, 1'b0);
        check("t5_sb_empty", sb.size(), 0);
        check("t5_transfers", transfers, 5);
        repeat (2) cycle();

        // Random backpressure, long run
        start_cmd(AW'($urandom), 1000);
        cycle();
        start = 1'b0;
        wait_done(6000, 1'b1);
        check("t6_sb_empty", sb.size(), 0);
        check("t6_transfers", transfers, 1000);
        check("t6_en_count", en_count, 1000);
        repeat (2) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
